conv_plane_acc: RTL and testbench
=================================

Name: conv_plane_acc

Overview:
- Downstream stage of the PIM conv array. Consumes the per-cycle ADC result (ADC_P bits, signed) that the array produces for each bit-plane of a bit-serial input vector.
- Shift-and-adds IN_BITS planes, MSB plane first, into one signed dot-product result.
- Presents the result on a valid/ready output handshake to the next layer or writeback logic.

Parameters:
- ADC_P, 8, width of the signed per-plane partial sum from the conv array
- IN_BITS, 8, number of input bit-planes per dot product; must be >= 2
- ACC_W, 20, accumulator/result width; must be >= ADC_P+IN_BITS

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a new accumulation
- in_valid  input  1  in_data holds a valid plane result this cycle
- in_data  input  ADC_P  signed partial sum from the conv array Output
- busy  output  1  high while in ACCUM
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_data  output  ACC_W  signed accumulated result
- drop_err  output  1  sticky flag: in_valid seen while not in ACCUM

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, plane_cnt=0, busy=0, out_valid=0, out_data=0, drop_err=0. Reset mid-accumulation discards partial results; no output is produced.
- States:
  - IDLE: start=1 -> ACCUM, acc<=0, plane_cnt<=0.
  - ACCUM: each cycle with in_valid=1 consumes one plane. After the plane with plane_cnt==IN_BITS-1 is consumed, go to DONE.
  - DONE: out_valid=1, out_data=acc held stable. out_ready=1 -> IDLE.
  - DONE with out_ready=1 and start=1 in the same cycle -> ACCUM directly (back-to-back, no idle bubble); acc and plane_cnt are cleared.
- Arithmetic:
  - in_data is sign-extended to ACC_W.
  - First plane (plane_cnt==0, the two's-complement MSB weight): acc <= -sext(in_data).
  - Later planes: acc <= (acc<<1) + sext(in_data).
  - All operations wrap modulo 2^ACC_W; there is no saturation.
- Latency: out_valid rises on the cycle after the final plane is accepted. start to out_valid is at least IN_BITS+1 cycles.
- in_valid gaps in ACCUM are allowed; acc and plane_cnt hold.
- start while in ACCUM is ignored. start in DONE without out_ready is ignored.
- in_valid in IDLE or DONE: data is ignored and drop_err<=1. drop_err is cleared only by reset.
- out_data holds its last value after the handshake until the next DONE.
- busy is a registered output, equal to (state==ACCUM).

Optional Feature:
- Macro: CONV_PLANE_ACC_RELU_EN.
- Defined: out_data is registered as 0 when the final acc is negative, else acc (ReLU applied on entry to DONE).
- Undefined: out_data is the raw signed acc.
- Internal accumulation is identical in both builds.

Test Plan:
- IN_BITS=4, ACC_W=16: start, then planes 3,1,0,2 on consecutive cycles -> out_valid one cycle after the 4th plane, out_data=0xFFEE (-18). With CONV_PLANE_ACC_RELU_EN defined -> 0x0000.
- Planes 0,5,0xFF(-1),7 with idle cycles between planes -> out_data=25; busy high from the cycle after start until the transition to DONE.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable. Then out_ready=1 together with start=1 -> next accumulation starts with no idle cycle and its result is correct (planes 1,1,1,1 -> out_data=-1).
- Pulse in_valid in IDLE with no start -> drop_err=1, acc unaffected. A following valid accumulation still produces the correct result and drop_err stays 1.
- Deassert rst after 2 of 4 planes, then restart with planes 0,0,0,1 -> out_data=1, with no contamination from the aborted run.
- ADC_P=8, IN_BITS=8, ACC_W=16, all planes 0x80 (-128) -> out_data = -128*(-128+127) = 128, i.e. 0x0080.

Source files
------------

// File: rtl/conv_plane_acc.sv
// conv_plane_acc: shift-and-add accumulator for the bit-serial PIM conv array.
// Consumes IN_BITS signed per-plane ADC results, MSB plane first, and presents
// the signed dot product on a valid/ready output.
// Optional build macro: CONV_PLANE_ACC_RELU_EN. When it is defined, the result
// register clamps negative dot products to zero. Accumulation is the same in
// both builds.
module conv_plane_acc #(
    parameter int ADC_P   = 8,
    parameter int IN_BITS = 8,
    parameter int ACC_W   = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [ADC_P-1:0] in_data,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             drop_err
);

    localparam int CNT_W = $clog2(IN_BITS);
    localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(IN_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic signed [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0]        plane_cnt;
    logic                    take, last_take, clear;

    // Sign-extend one ADC plane result to the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext(input logic [ADC_P-1:0] d);
        return {{(ACC_W - ADC_P){d[ADC_P-1]}}, d};
    endfunction

    // One shift-and-add step. The MSB plane carries negative weight in two's
    // complement, so the first plane is subtracted rather than added.
    function automatic logic signed [ACC_W-1:0] plane_step(
        input logic signed [ACC_W-1:0] a,
        input logic [ADC_P-1:0]        d,
        input logic                    first
    );
        if (first) return -sext(d);
        return (a <<< 1) + sext(d);
    endfunction

    // Output shaping applied when the result is captured into out_data.
    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef CONV_PLANE_ACC_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign take      = (state == ACCUM) && in_valid;
    assign last_take = take && (plane_cnt == LAST_PLANE);
    assign clear     = start && ((state == IDLE) || ((state == DONE) && out_ready));
    assign acc_next  = plane_step(acc, in_data, plane_cnt == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic; a handshake with start in DONE goes straight back to ACCUM.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_take) state_next = DONE;
            DONE: begin
                if (out_ready) state_next = start ? ACCUM : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered status outputs and the sticky dropped-plane flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            busy      <= (state_next == ACCUM);
            out_valid <= (state_next == DONE);
            if (in_valid && (state != ACCUM)) drop_err <= 1'b1;
        end
    end

    // Accumulator, plane counter and result capture; out_data only changes on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            plane_cnt <= '0;
            out_data  <= '0;
        end else if (clear) begin
            acc       <= '0;
            plane_cnt <= '0;
        end else if (take) begin
            acc <= acc_next;
            if (last_take) begin
                plane_cnt <= '0;
                out_data  <= relu(acc_next);
            end else begin
                plane_cnt <= plane_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_plane_acc.sv
// Directed bench for conv_plane_acc: a 4-plane/16-bit instance for most cases
// and an 8-plane/16-bit instance for the all-minimum-plane boundary case.
module tb_conv_plane_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start, a_in_valid, a_busy, a_out_valid, a_out_ready, a_drop_err;
    logic [7:0]  a_in_data;
    logic [15:0] a_out_data;
    logic        b_start, b_in_valid, b_busy, b_out_valid, b_out_ready, b_drop_err;
    logic [7:0]  b_in_data;
    logic [15:0] b_out_data;

    conv_plane_acc #(.ADC_P(8), .IN_BITS(4), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
        .busy(a_busy), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .drop_err(a_drop_err)
    );

    conv_plane_acc #(.ADC_P(8), .IN_BITS(8), .ACC_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .busy(b_busy), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .drop_err(b_drop_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] planes;   // plane 0 in bits [31:24]
        int          gap;      // idle cycles between planes
        logic [15:0] expected; // raw signed dot product
    } vec_t;

    vec_t tbl [6];

    function automatic logic [15:0] shape(input logic [15:0] v);
`ifdef CONV_PLANE_ACC_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed four planes into dut_a; optionally raise start during the gap cycles.
    task automatic feed_a(input logic [31:0] planes, input int gap, input logic poke_start,
                          input string name);
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = planes[31 - 8*i -: 8];
            tick();
            a_in_valid = 1'b0;
            if (i < 3) begin
                chk({name, " busy_mid"}, a_busy, 1);
                chk({name, " valid_early"}, a_out_valid, 0);
                for (int g = 0; g < gap; g++) begin
                    a_start = poke_start;
                    tick();
                    a_start = 1'b0;
                    chk({name, " busy_gap"}, a_busy, 1);
                end
            end
        end
        chk({name, " valid"}, a_out_valid, 1);
        chk({name, " busy_done"}, a_busy, 0);
    endtask

    task automatic start_a(input string name);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk({name, " busy_start"}, a_busy, 1);
        chk({name, " valid_start"}, a_out_valid, 0);
    endtask

    task automatic handshake_a(input string name, input logic [15:0] held);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk({name, " valid_after_hs"}, a_out_valid, 0);
        chk({name, " data_hold"}, a_out_data, held);
    endtask

    initial begin
        tbl[0] = '{32'h03_01_00_02, 0, 16'hFFEE};
        tbl[1] = '{32'h00_05_FF_07, 2, 16'h0019};
        tbl[2] = '{32'h01_01_01_01, 0, 16'hFFFF};
        tbl[3] = '{32'h00_00_00_01, 1, 16'h0001};
        tbl[4] = '{32'h7F_7F_7F_7F, 0, 16'hFF81};
        tbl[5] = '{32'h80_00_00_00, 0, 16'h0400};

        a_start = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_start = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;

        #2 rst = 1'b0;
        tick();
        tick();
        chk("reset busy", a_busy, 0);
        chk("reset out_valid", a_out_valid, 0);
        chk("reset out_data", a_out_data, 0);
        chk("reset drop_err", a_drop_err, 0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            start_a(nm);
            feed_a(tbl[v].planes, tbl[v].gap, 1'b0, nm);
            chk({nm, " out_data"}, a_out_data, shape(tbl[v].expected));
            handshake_a(nm, shape(tbl[v].expected));
        end
        chk("no drop after table", a_drop_err, 0);

        // Back-pressure in DONE, an ignored start there, then back-to-back restart.
        start_a("hold");
        feed_a(32'h03_01_00_02, 0, 1'b0, "hold");
        for (int c = 0; c < 5; c++) begin
            a_start = (c == 2);
            tick();
            a_start = 1'b0;
            chk("hold valid", a_out_valid, 1);
            chk("hold data", a_out_data, shape(16'hFFEE));
        end
        a_out_ready = 1'b1;
        a_start     = 1'b1;
        tick();
        a_out_ready = 1'b0;
        a_start     = 1'b0;
        chk("b2b valid_low", a_out_valid, 0);
        chk("b2b busy", a_busy, 1);
        chk("b2b data_hold", a_out_data, shape(16'hFFEE));
        feed_a(32'h01_01_01_01, 0, 1'b0, "b2b");
        chk("b2b out_data", a_out_data, shape(16'hFFFF));
        handshake_a("b2b", shape(16'hFFFF));

        // Stray plane in IDLE, then a run with start poked while accumulating.
        a_in_valid = 1'b1;
        a_in_data  = 8'h55;
        tick();
        a_in_valid = 1'b0;
        chk("drop set", a_drop_err, 1);
        chk("drop no busy", a_busy, 0);
        start_a("drop");
        feed_a(32'h00_05_FF_07, 2, 1'b1, "drop");
        chk("drop out_data", a_out_data, 16'h0019);
        chk("drop sticky", a_drop_err, 1);
        handshake_a("drop", 16'h0019);

        // Reset in the middle of an accumulation, then a clean run.
        start_a("abort");
        a_in_valid = 1'b1; a_in_data = 8'h40; tick();
        a_in_valid = 1'b1; a_in_data = 8'h40; tick();
        a_in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort busy", a_busy, 0);
        chk("abort out_valid", a_out_valid, 0);
        chk("abort out_data", a_out_data, 0);
        chk("abort drop_err", a_drop_err, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("abort idle valid", a_out_valid, 0);
        start_a("restart");
        feed_a(32'h00_00_00_01, 0, 1'b0, "restart");
        chk("restart out_data", a_out_data, 16'h0001);
        handshake_a("restart", 16'h0001);

        // Eight planes of the most negative ADC code on the 8-plane instance.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b busy", b_busy, 1);
        for (int i = 0; i < 8; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'h80;
            tick();
            b_in_valid = 1'b0;
            if (i < 7) chk("b valid_early", b_out_valid, 0);
        end
        chk("b valid", b_out_valid, 1);
        chk("b out_data", b_out_data, 16'h0080);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("b valid_after_hs", b_out_valid, 0);
        chk("b drop_err", b_drop_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
